// File: rtl/hamming_pkg.sv
// Shared constants, status encoding and codeword layout helpers for the
// Hamming SEC/SECDED decoder family.
package hamming_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_CORR,
      ERR_UNCORR
   } err_status_t;

   function automatic int calc_n(input int r);
      return (1 << r) - 1;
   endfunction

   function automatic int calc_k(input int r);
      return calc_n(r) - r;
   endfunction

   // Data bits occupy the non-power-of-two positions in ascending order.
   // The search bound is always past the wanted position because only
   // about log2(p) of the positions below p are parity positions.
   function automatic int data_pos(input int idx);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 3; p < 2 * idx + 8; p++) begin
         if (((p & (p - 1)) != 0) && (pos == 0)) begin
            if (cnt == idx) begin
               pos = p;
            end
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome and overall-parity evaluation for one received
// codeword (bit p-1 holds Hamming position p).
module hamming_syndrome_calc
   import hamming_pkg::*;
#(
   parameter int R      = 3,
   parameter int SECDED = 1,
   localparam int N     = calc_n(R)
) (
   input  logic [N+SECDED-1:0] code,
   output logic [R-1:0]        syndrome,
   output logic                parity_err
);

   // Every set bit contributes its own position to the syndrome, which is
   // the same as XOR-ing, for each syndrome bit j, all positions with bit j set.
   always_comb begin
      syndrome = '0;
      for (int p = 1; p <= N; p++) begin
         if (code[p-1]) begin
            syndrome = syndrome ^ R'(p);
         end
      end
   end

   generate
      if (SECDED != 0) begin : g_parity
         assign parity_err = ^code;
      end else begin : g_no_parity
         assign parity_err = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming decoder: S1 captures syndrome/parity/raw word,
// S2 corrects, extracts data and raises status; saturating error counters.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int R      = 3,
   parameter int SECDED = 1,
   parameter int CNT_W  = 16,
   localparam int N     = calc_n(R),
   localparam int K     = calc_k(R),
   localparam int W     = N + SECDED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     out_data,
   output logic [R-1:0]     out_syndrome,
   output logic             out_err_single,
   output logic             out_err_double,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_corr,
   output logic [CNT_W-1:0] cnt_uncorr
);

   logic          s1_valid;
   logic [W-1:0]  s1_code;
   logic [R-1:0]  s1_syn;
   logic          s1_par;
   logic [R-1:0]  calc_syn;
   logic          calc_par;
   logic          s1_load;
   logic          s2_load;
   logic          out_hs;
   err_status_t   status;
   logic [W-1:0]  fixed_code;
   logic [K-1:0]  fixed_data;

   hamming_syndrome_calc #(
      .R      (R),
      .SECDED (SECDED)
   ) u_syndrome (
      .code       (in_code),
      .syndrome   (calc_syn),
      .parity_err (calc_par)
   );

   // S2 takes a word whenever it is empty or its word leaves this cycle,
   // and S1 frees up exactly when S2 takes from it.
   assign out_hs   = out_valid && out_ready;
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;
   assign s1_load  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_code  <= in_code;
         s1_syn   <= calc_syn;
         s1_par   <= calc_par;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Odd overall parity means one flipped bit (possibly the parity bit itself);
   // even parity with a nonzero syndrome can only be two flips.
   always_comb begin
      status = ERR_NONE;
      if (SECDED != 0) begin
         if (s1_par) begin
            status = ERR_CORR;
         end else if (s1_syn != '0) begin
            status = ERR_UNCORR;
         end
      end else if (s1_syn != '0) begin
         status = ERR_CORR;
      end
   end

   always_comb begin
      fixed_code = s1_code;
      if (status == ERR_CORR) begin
         for (int p = 1; p <= N; p++) begin
            if (R'(p) == s1_syn) begin
               fixed_code[p-1] = ~s1_code[p-1];
            end
         end
      end
      fixed_data = '0;
      for (int i = 0; i < K; i++) begin
         fixed_data[i] = fixed_code[data_pos(i) - 1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_syndrome   <= '0;
         out_err_single <= 1'b0;
         out_err_double <= 1'b0;
      end else if (s2_load) begin
         out_valid      <= 1'b1;
         out_data       <= fixed_data;
         out_syndrome   <= s1_syn;
         out_err_single <= (status == ERR_CORR);
         out_err_double <= (status == ERR_UNCORR);
      end else if (out_ready) begin
         out_valid      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (clr_cnt) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (out_hs) begin
         if (out_err_single && (cnt_corr != '1)) begin
            cnt_corr <= cnt_corr + 1'b1;
         end
         if (out_err_double && (cnt_uncorr != '1)) begin
            cnt_uncorr <= cnt_uncorr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (R=3, SECDED=1, CNT_W=2) with
// hand-computed expectations checked by immediate assertions.
module tb_hamming_secded_decoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       out_err_single;
   logic       out_err_double;
   logic       clr_cnt;
   logic [1:0] cnt_corr;
   logic [1:0] cnt_uncorr;

   int compared;
   int mismatched;

   hamming_secded_decoder #(
      .R      (3),
      .SECDED (1),
      .CNT_W  (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_code        (in_code),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_syndrome   (out_syndrome),
      .out_err_single (out_err_single),
      .out_err_double (out_err_double),
      .clr_cnt        (clr_cnt),
      .cnt_corr       (cnt_corr),
      .cnt_uncorr     (cnt_uncorr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one word with out_ready high and confirm the two-cycle latency.
   task automatic applyStimulus(input logic [7:0] code, input string tag);
      in_valid = 1'b1;
      in_code  = code;
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1_valid"}, out_valid, 1'b0);
      tick();
      check({tag, "_lat2_valid"}, out_valid, 1'b1);
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] data, input logic [2:0] syn,
                              input logic single, input logic dbl);
      check({tag, "_valid"},  out_valid,      1'b1);
      check({tag, "_data"},   out_data,       data);
      check({tag, "_syn"},    out_syndrome,   syn);
      check({tag, "_single"}, out_err_single, single);
      check({tag, "_double"}, out_err_double, dbl);
   endtask

   task automatic clearCounters();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_code    = 8'h00;
      out_ready  = 1'b1;
      clr_cnt    = 1'b0;
      $display("[TB] start");

      tick();
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 4'h0);
      check("rst_out_syn", out_syndrome, 3'b000);
      check("rst_cnt_corr", cnt_corr, 2'd0);
      check("rst_cnt_uncorr", cnt_uncorr, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", in_ready, 1'b1);

      applyStimulus(8'h55, "clean");
      checkOutput("clean", 4'hB, 3'b000, 1'b0, 1'b0);
      tick();
      check("clean_cnt_corr", cnt_corr, 2'd0);
      check("clean_cnt_uncorr", cnt_uncorr, 2'd0);
      check("clean_drained", out_valid, 1'b0);

      applyStimulus(8'h45, "single");
      checkOutput("single", 4'hB, 3'b101, 1'b1, 1'b0);
      tick();
      check("single_cnt_corr", cnt_corr, 2'd1);

      applyStimulus(8'h44, "double");
      checkOutput("double", 4'h9, 3'b100, 1'b0, 1'b1);
      tick();
      check("double_cnt_uncorr", cnt_uncorr, 2'd1);
      check("double_cnt_corr", cnt_corr, 2'd1);

      applyStimulus(8'hD5, "pbit");
      checkOutput("pbit", 4'hB, 3'b000, 1'b1, 1'b0);
      tick();
      check("pbit_cnt_corr", cnt_corr, 2'd2);

      clearCounters();
      check("clr_cnt_corr", cnt_corr, 2'd0);
      check("clr_cnt_uncorr", cnt_uncorr, 2'd0);

      // Backpressure: four words back-to-back while the consumer stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 8'h55;
      tick();
      check("bp_ready_one_held", in_ready, 1'b1);
      in_code = 8'h45;
      tick();
      check("bp_ready_two_held", in_ready, 1'b0);
      checkOutput("bp_hold0", 4'hB, 3'b000, 1'b0, 1'b0);
      in_code = 8'h44;
      tick();
      check("bp_ready_stall1", in_ready, 1'b0);
      checkOutput("bp_hold1", 4'hB, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("bp_hold2", 4'hB, 3'b000, 1'b0, 1'b0);
      check("bp_cnt_stalled", cnt_corr, 2'd0);
      out_ready = 1'b1;
      #1;
      check("bp_ready_release", in_ready, 1'b1);
      tick();
      checkOutput("bp_w1", 4'hB, 3'b101, 1'b1, 1'b0);
      in_code = 8'hD5;
      tick();
      in_valid = 1'b0;
      checkOutput("bp_w2", 4'h9, 3'b100, 1'b0, 1'b1);
      tick();
      checkOutput("bp_w3", 4'hB, 3'b000, 1'b1, 1'b0);
      tick();
      check("bp_drained", out_valid, 1'b0);
      check("bp_cnt_corr", cnt_corr, 2'd2);
      check("bp_cnt_uncorr", cnt_uncorr, 2'd1);

      // Saturation of the 2-bit corrected counter.
      clearCounters();
      in_valid = 1'b1;
      in_code  = 8'h45;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("sat_drained", out_valid, 1'b0);
      check("sat_cnt_corr", cnt_corr, 2'd3);
      check("sat_cnt_uncorr", cnt_uncorr, 2'd0);

      applyStimulus(8'h45, "clrhs");
      check("clrhs_cnt_before", cnt_corr, 2'd3);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("clrhs_cnt_corr", cnt_corr, 2'd0);
      check("clrhs_delivered", out_valid, 1'b0);

      // Reset with one word in S2 and another in S1.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 8'h44;
      tick();
      in_code = 8'h45;
      tick();
      in_valid = 1'b0;
      check("inflight_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("inflight_rst_valid", out_valid, 1'b0);
      check("inflight_rst_data", out_data, 4'h0);
      check("inflight_rst_double", out_err_double, 1'b0);
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_no_stale", out_valid, 1'b0);
      end
      check("post_rst_cnt_corr", cnt_corr, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
Parametrised, pipelined Hamming decoder. It is the successor to the combinational 7-bit syndrome detector. It computes the syndrome of each received codeword, corrects single-bit errors and optionally detects double-bit errors (SECDED). It also extracts the data bits and keeps saturating error-statistics counters. It sits between the receive/codeword source and the data consumer, with valid/ready handshakes on both sides.

Parameters:
R, 3, number of Hamming parity bits (R>=2); N = 2^R-1 codeword bits, K = N-R data bits
SECDED, 1, 1 = extra overall-parity bit at index N (double-error detect); 0 = plain SEC
CNT_W, 16, width of each error counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  codeword on in_code is valid
in_ready  output  1  block accepts a codeword this cycle
in_code  input  N+SECDED  received codeword; bit p-1 = Hamming position p; bit N = overall parity when SECDED=1
out_valid  output  1  decoded word available
out_ready  input  1  consumer accepts the decoded word
out_data  output  K  corrected data bits
out_syndrome  output  R  syndrome of this word
out_err_single  output  1  single error detected and corrected (includes an overall-parity-bit-only error)
out_err_double  output  1  uncorrectable double error (SECDED=1 only; tied 0 otherwise)
clr_cnt  input  1  synchronous clear of both counters
cnt_corr  output  CNT_W  number of delivered words with out_err_single
cnt_uncorr  output  CNT_W  number of delivered words with out_err_double

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: out_valid=0; out_data, out_syndrome, out_err_* = 0; both counters = 0; pipeline stages empty. in_ready=1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight words immediately.
- Bit layout: parity bits sit at power-of-two positions (1,2,4,...). Data bits fill the remaining positions in ascending order, so data bit 0 is at position 3. For R=3 the layout is [i3,i2,i1,c2,i0,c1,c0].
- Syndrome bit j = XOR of every in_code bit whose position p has bit j set.
- Overall parity check (SECDED=1) = XOR of all N+1 bits; 1 means odd, i.e. an error is present.
- Classification when SECDED=1:
  - s==0, parity even: no error.
  - s!=0, parity odd: single error; flip the bit at position s.
  - s==0, parity odd: single error in the overall-parity bit; data unchanged.
  - s!=0, parity even: double error; data passed through uncorrected; out_err_double=1.
- Classification when SECDED=0: s!=0 means single error at position s, corrected.
- Pipeline, 2 stages:
  - S1 registers the syndrome, the parity flag and the raw codeword.
  - S2 registers the corrected data and the status flags.
  - Latency is 2 cycles from the in_valid && in_ready edge to out_valid when there are no stalls.
  - Throughput is 1 word per cycle.
- Stage advance: a stage loads when it is empty or when its content moves on in the same cycle.
  - in_ready = !S1_full || S1 advancing.
  - S2 advances on out_valid && out_ready.
- Stall: while out_valid && !out_ready, all out_* values are held stable.
  - At most 2 words are held (S1 + S2).
  - No word is lost or duplicated; order is preserved.
- Counters:
  - Increment by 1 on each output handshake, according to that word's flags.
  - Saturate at all ones; no wrap.
  - When clr_cnt and an increment occur in the same cycle, clr wins and the counter becomes 0.

Decomposition:
- Package hamming_pkg holds:
  - the constant functions calc_n(R) and calc_k(R);
  - typedef enum err_status_t {ERR_NONE, ERR_CORR, ERR_UNCORR};
  - a function that maps data index to codeword position.
- Sub-module hamming_syndrome_calc (combinational, parameter R, SECDED) outputs the syndrome and the overall-parity flag. It is instantiated in S1.

Test Plan:
- Clean word: R=3, SECDED=1, in_code=8'h55 -> 2 cycles later out_data=4'hB, out_syndrome=3'b000, both error flags 0, counters unchanged.
- Single error: in_code=8'h45 (position 5 flipped) -> out_data=4'hB, out_syndrome=3'b101, out_err_single=1, cnt_corr=1.
- Double error: in_code=8'h44 (positions 1 and 5 flipped) -> out_syndrome=3'b100, out_err_double=1, out_data=4'h9 (uncorrected), cnt_uncorr=1.
- Overall-parity-bit error: in_code=8'hD5 -> out_data=4'hB, out_syndrome=0, out_err_single=1.
- Backpressure: send 4 words back-to-back (8'h55, 8'h45, 8'h44, 8'hD5) with out_ready=0 for 4 cycles -> in_ready drops once 2 words are held, out_* stay stable, then the 4 results emerge in order with none lost.
- Saturation, clear and reset: CNT_W=2, 5 single-error words -> cnt_corr=3. clr_cnt together with a 6th single-error word -> cnt_corr=0. rst_n low while a word is in flight -> out_valid=0 immediately and no stale output appears after release.
